// File: rtl/simple_param_pkg.sv
// Shared defaults and types for the parameter-controlled shift/add responder.
package simple_param_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int SHIFT_W_DEF  = 3;
    localparam int COMMIT_CNT_W = 8;

    typedef enum logic [1:0] {
        PARAM_OPT1_F = 2'd0,
        PARAM_RSVD1  = 2'd1,
        PARAM_RSVD2  = 2'd2,
        PARAM_RSVD3  = 2'd3
    } param_addr_e;

endpackage

// File: rtl/simple_commit_edge.sv
// Rising-edge detector on the commit request level, with a registered one-cycle ack.
module simple_commit_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic fire,
    output logic ack
);

    logic prev;

    // Combinational so the commit lands on the same edge that sees the rise.
    assign fire = level & ~prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
            ack  <= 1'b0;
        end else begin
            prev <= level;
            ack  <= fire;
        end
    end

endmodule

// File: rtl/simple_param_responder.sv
// Two-stage shift-then-saturating-add datapath with a shadowed, commit-on-edge shift parameter.
module simple_param_responder
    import simple_param_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic                    param_wr,
    input  logic [1:0]              param_addr,
    input  logic [DATA_W-1:0]       param_wdata,
    input  logic                    param_valid,
    output logic                    param_ack,
    input  logic [DATA_W-1:0]       inputArg1,
    input  logic [DATA_W-1:0]       inputArg2,
    output logic [DATA_W-1:0]       outputArg11,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       opt1_active,
    output logic [COMMIT_CNT_W-1:0] commit_count
);

    logic [DATA_W-1:0] shadow;
    logic              commit;

    simple_commit_edge u_commit (
        .clk   (clk),
        .reset (reset),
        .level (param_valid),
        .fire  (commit),
        .ack   (param_ack)
    );

    // Parameter path runs every cycle; clk_enable only qualifies the datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow       <= '0;
            opt1_active  <= '0;
            commit_count <= '0;
        end else begin
            if (param_wr && param_addr_e'(param_addr) == PARAM_OPT1_F)
                shadow <= param_wdata;
            if (commit) begin
                opt1_active  <= shadow;
                commit_count <= commit_count + 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] a1, b1;
    logic [DATA_W:0]   sum;
    logic [1:0]        vld_pipe;

    assign sum       = {1'b0, a1} + {1'b0, b1};
    assign out_valid = vld_pipe[1];

    // Stage 1 samples the live opt1_active, so a commit only affects new samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1          <= '0;
            b1          <= '0;
            outputArg11 <= '0;
            vld_pipe    <= '0;
        end else if (clk_enable) begin
            a1          <= inputArg1 >> opt1_active[SHIFT_W-1:0];
            b1          <= inputArg2;
            outputArg11 <= sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
            vld_pipe    <= {vld_pipe[0], 1'b1};
        end
    end

endmodule
